// File: rtl/missile_pkg.sv
// Shared screen geometry, palette and probe FSM types for the missile-command video path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package missile_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOR_W  = 3;

  // Named palette entries used by the renderer and by probes.
  typedef enum logic [COLOR_W-1:0] {
    COLOR_BACKGROUND = 3'b000,
    COLOR_CITY       = 3'b010,
    COLOR_MISSILE    = 3'b100,
    COLOR_DEFAULT    = 3'b111
  } color_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_RESP
  } probe_state_e;

  // Clamp an inclusive upper bound to the last valid index.
  function automatic logic [8:0] clip_bound(input logic [8:0] v, input logic [8:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/pixel_addr.sv
// Framebuffer word address from pixel coordinates: addr = y*SCREEN_W + x.
// Latency: combinational.
// Backpressure: none.
// Ports: x (column), y (row) in; addr (17-bit word address) out.
module pixel_addr #(
  parameter int SCREEN_W = missile_pkg::SCREEN_W
) (
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  output logic [16:0] addr
);

  generate
    if (SCREEN_W == 320) begin : g_shift
      // 320 = 256 + 64, so two shifts and an add replace the multiplier.
      assign addr = ({9'd0, y} << 8) + ({9'd0, y} << 6) + {8'd0, x};
    end else begin : g_mul
      assign addr = ({9'd0, y} * 17'(SCREEN_W)) + {8'd0, x};
    end
  endgenerate

endmodule

// File: rtl/pixel_probe.sv
// Scans a rectangular framebuffer region in raster order and reports matches against a colour.
// Latency: N-pixel region -> rd_en on T+1..T+N, rsp_valid from T+N+2 (empty region: T+1).
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
// Ports: req_* probe request (valid/ready); rd_en/rd_addr/rd_data framebuffer read with
//        1-cycle data return; rsp_* result (valid/ready) with hit flag, first hit x/y, count.
module pixel_probe
  import missile_pkg::*;
#(
  parameter int SCREEN_W = missile_pkg::SCREEN_W,
  parameter int SCREEN_H = missile_pkg::SCREEN_H,
  parameter int COLOR_W  = missile_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [8:0]         req_x0,
  input  logic [8:0]         req_x1,
  input  logic [7:0]         req_y0,
  input  logic [7:0]         req_y1,
  input  logic [COLOR_W-1:0] req_color,
  output logic               rd_en,
  output logic [16:0]        rd_addr,
  input  logic [COLOR_W-1:0] rd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_hit,
  output logic [8:0]         rsp_hit_x,
  output logic [7:0]         rsp_hit_y,
  output logic [16:0]        rsp_count
);

  localparam logic [8:0] X_MAX = 9'(SCREEN_W - 1);
  localparam logic [8:0] Y_MAX = 9'(SCREEN_H - 1);

  probe_state_e       state_q, state_d;
  logic               req_ready_q, req_ready_d;
  logic               rd_en_q, rd_en_d;
  logic [16:0]        rd_addr_q, rd_addr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic [8:0]         rsp_hit_x_q, rsp_hit_x_d;
  logic [7:0]         rsp_hit_y_q, rsp_hit_y_d;
  logic [16:0]        rsp_count_q, rsp_count_d;

  // Latched request (x1/y1 already clipped).
  logic [8:0]         x0_q, x0_d;
  logic [8:0]         x1_q, x1_d;
  logic [7:0]         y1_q, y1_d;
  logic [COLOR_W-1:0] color_q, color_d;

  // Coordinates of the pixel whose read is on the bus this cycle.
  logic [8:0]         iss_x_q, iss_x_d;
  logic [7:0]         iss_y_q, iss_y_d;

  // Same coordinates delayed one cycle so they line up with rd_data.
  logic               cmp_vld_q, cmp_vld_d;
  logic [8:0]         cmp_x_q, cmp_x_d;
  logic [7:0]         cmp_y_q, cmp_y_d;

  logic [8:0]         req_x1_clip;
  logic [7:0]         req_y1_clip;
  logic               req_empty;
  logic [8:0]         nxt_x;
  logic [7:0]         nxt_y;
  logic [16:0]        nxt_addr;
  logic               scan_last;
  logic               pix_match;

  assign req_x1_clip = clip_bound(req_x1, X_MAX);
  assign req_y1_clip = 8'(clip_bound({1'b0, req_y1}, Y_MAX));
  // An x0/y0 beyond the screen is always above the clipped bound, so it lands here too.
  assign req_empty   = (req_x0 > req_x1_clip) || (req_y0 > req_y1_clip);

  // Next pixel to issue: region origin when starting, otherwise raster successor.
  always_comb begin
    nxt_x = iss_x_q;
    nxt_y = iss_y_q;
    if (state_q == ST_IDLE) begin
      nxt_x = req_x0;
      nxt_y = req_y0;
    end else if (iss_x_q == x1_q) begin
      nxt_x = x0_q;
      nxt_y = iss_y_q + 8'd1;
    end else begin
      nxt_x = iss_x_q + 9'd1;
    end
  end

  assign scan_last = (iss_x_q == x1_q) && (iss_y_q == y1_q);

  pixel_addr #(.SCREEN_W(SCREEN_W)) u_pixel_addr (
    .x    (nxt_x),
    .y    (nxt_y),
    .addr (nxt_addr)
  );

  // rd_data is only meaningful in the cycle after a read strobe.
  assign pix_match = cmp_vld_q && (rd_data == color_q);

  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = 17'd0;
    rsp_hit_d   = rsp_hit_q;
    rsp_hit_x_d = rsp_hit_x_q;
    rsp_hit_y_d = rsp_hit_y_q;
    rsp_count_d = rsp_count_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    color_d     = color_q;
    iss_x_d     = iss_x_q;
    iss_y_d     = iss_y_q;
    cmp_vld_d   = rd_en_q;
    cmp_x_d     = iss_x_q;
    cmp_y_d     = iss_y_q;

    if (pix_match) begin
      rsp_count_d = rsp_count_q + 17'd1;
      if (!rsp_hit_q) begin
        rsp_hit_d   = 1'b1;
        rsp_hit_x_d = cmp_x_q;
        rsp_hit_y_d = cmp_y_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          x0_d        = req_x0;
          x1_d        = req_x1_clip;
          y1_d        = req_y1_clip;
          color_d     = req_color;
          rsp_hit_d   = 1'b0;
          rsp_hit_x_d = 9'd0;
          rsp_hit_y_d = 8'd0;
          rsp_count_d = 17'd0;
          if (req_empty) begin
            state_d = ST_RESP;
          end else begin
            state_d   = ST_SCAN;
            rd_en_d   = 1'b1;
            rd_addr_d = nxt_addr;
            iss_x_d   = nxt_x;
            iss_y_d   = nxt_y;
          end
        end
      end
      ST_SCAN: begin
        if (scan_last) begin
          state_d = ST_DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = nxt_addr;
          iss_x_d   = nxt_x;
          iss_y_d   = nxt_y;
        end
      end
      // One cycle: the final pixel's data is compared here.
      ST_DRAIN: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= 17'd0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_hit_x_q <= 9'd0;
      rsp_hit_y_q <= 8'd0;
      rsp_count_q <= 17'd0;
      x0_q        <= 9'd0;
      x1_q        <= 9'd0;
      y1_q        <= 8'd0;
      color_q     <= '0;
      iss_x_q     <= 9'd0;
      iss_y_q     <= 8'd0;
      cmp_vld_q   <= 1'b0;
      cmp_x_q     <= 9'd0;
      cmp_y_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_hit_x_q <= rsp_hit_x_d;
      rsp_hit_y_q <= rsp_hit_y_d;
      rsp_count_q <= rsp_count_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      iss_x_q     <= iss_x_d;
      iss_y_q     <= iss_y_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_x_q     <= cmp_x_d;
      cmp_y_q     <= cmp_y_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_hit_x = rsp_hit_x_q;
  assign rsp_hit_y = rsp_hit_y_q;
  assign rsp_count = rsp_count_q;

endmodule

// File: tb/tb_pixel_probe.sv
// Scoreboard bench for pixel_probe: raster model pushes expected addresses and results
// at request time; a negedge monitor pops and compares reads and responses.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_pixel_probe;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_x0, req_x1;
  logic [7:0]  req_y0, req_y1;
  logic [2:0]  req_color;
  logic        rd_en;
  logic [16:0] rd_addr;
  logic [2:0]  rd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_hit;
  logic [8:0]  rsp_hit_x;
  logic [7:0]  rsp_hit_y;
  logic [16:0] rsp_count;

  always #5 clk = ~clk;

  pixel_probe #(.SCREEN_W(320), .SCREEN_H(240), .COLOR_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x0    (req_x0),
    .req_x1    (req_x1),
    .req_y0    (req_y0),
    .req_y1    (req_y1),
    .req_color (req_color),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_hit   (rsp_hit),
    .rsp_hit_x (rsp_hit_x),
    .rsp_hit_y (rsp_hit_y),
    .rsp_count (rsp_count)
  );

  // Framebuffer: one-cycle read latency; garbage on cycles without a read.
  logic [2:0] fb [0:76799];
  always @(posedge clk) rd_data <= rd_en ? fb[rd_addr] : 3'($urandom);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int n;
    int cnt;
    int hit;
    int hx;
    int hy;
    int acc_c;
  } exp_t;

  exp_t sb[$];
  int   addr_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   rd_cnt = 0;
  int   first_rd = 0;
  int   last_rd = 0;
  bit   rsp_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", tag, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      addr_q.delete();
      rd_cnt   = 0;
      rsp_seen = 1'b0;
    end else begin
      if (rd_en) begin
        if (addr_q.size() == 0) begin
          chk("rd_en_spurious", 32'(rd_en), 0);
        end else begin
          chk("rd_addr", 32'(rd_addr), addr_q.pop_front());
          if (rd_cnt == 0) first_rd = cyc;
          last_rd = cyc;
          rd_cnt++;
        end
      end else begin
        chk("rd_addr_idle", 32'(rd_addr), 0);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_spurious", 32'(rsp_valid), 0);
        end else begin
          mon_e = sb[0];
          if (!rsp_seen) begin
            rsp_seen = 1'b1;
            chk("rsp_latency", cyc - mon_e.acc_c, (mon_e.n == 0) ? 1 : mon_e.n + 2);
          end
          if (rsp_ready) begin
            chk("rsp_hit",   32'(rsp_hit),   mon_e.hit);
            chk("rsp_hit_x", 32'(rsp_hit_x), mon_e.hx);
            chk("rsp_hit_y", 32'(rsp_hit_y), mon_e.hy);
            chk("rsp_count", 32'(rsp_count), mon_e.cnt);
            chk("rd_cnt",    rd_cnt,         mon_e.n);
            if (mon_e.n > 0) begin
              chk("rd_first", first_rd - mon_e.acc_c, 1);
              chk("rd_span",  last_rd - first_rd + 1, mon_e.n);
            end
            void'(sb.pop_front());
            rsp_seen = 1'b0;
            rd_cnt   = 0;
            done_cnt++;
          end
        end
      end
    end
  end

  // Raster reference model: expected reads and result for one request.
  task automatic push_exp(input int x0, input int x1, input int y0, input int y1,
                          input int color, input int acc_c);
    exp_t e;
    int   xc, yc;
    xc = (x1 > 319) ? 319 : x1;
    yc = (y1 > 239) ? 239 : y1;
    e  = '{n: 0, cnt: 0, hit: 0, hx: 0, hy: 0, acc_c: acc_c};
    for (int y = y0; y <= yc; y++) begin
      for (int x = x0; x <= xc; x++) begin
        addr_q.push_back(y * 320 + x);
        e.n++;
        if (fb[y * 320 + x] == 3'(color)) begin
          if (e.hit == 0) begin
            e.hit = 1;
            e.hx  = x;
            e.hy  = y;
          end
          e.cnt++;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic fill(input logic [2:0] v);
    for (int i = 0; i < 76800; i++) fb[i] = v;
  endtask

  task automatic fill_rand(input int maxc);
    for (int i = 0; i < 76800; i++) fb[i] = 3'($urandom_range(0, maxc));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && !req_ready; i++) @(negedge clk);
    chk("req_ready_wait", 32'(req_ready), 1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 5000 && done_cnt < target; i++) @(negedge clk);
    chk("done_timeout", done_cnt, target);
  endtask

  // Issue one request; fields are scrambled right after acceptance.
  task automatic probe(input int x0, input int x1, input int y0, input int y1, input int color);
    wait_idle();
    @(posedge clk);
    #1;
    req_x0    = 9'(x0);
    req_x1    = 9'(x1);
    req_y0    = 8'(y0);
    req_y1    = 8'(y1);
    req_color = 3'(color);
    req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_accept", 32'(req_ready), 1);
    push_exp(int'(req_x0), int'(req_x1), int'(req_y0), int'(req_y1), color, cyc);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_x0    = 9'($urandom);
    req_x1    = 9'($urandom);
    req_y0    = 8'($urandom);
    req_y1    = 8'($urandom);
    req_color = 3'($urandom);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  int          exp_done;
  int          k;
  logic [31:0] h_hit, h_x, h_y, h_cnt;

  initial begin
    exp_done  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_x0    = '0;
    req_x1    = '0;
    req_y0    = '0;
    req_y1    = '0;
    req_color = '0;
    rsp_ready = 1'b1;
    fill(3'b000);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_rd_en",     32'(rd_en),     0);
    chk("rst_rd_addr",   32'(rd_addr),   0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_hit",   32'(rsp_hit),   0);
    chk("rst_hit_x",     32'(rsp_hit_x), 0);
    chk("rst_hit_y",     32'(rsp_hit_y), 0);
    chk("rst_count",     32'(rsp_count), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 16x10 block, every pixel matches.
    fill(3'b111);
    probe(152, 167, 200, 209, 3'b111);
    wait_done(++exp_done);

    // Single matching pixel inside a background region.
    fill(3'b000);
    fb[205 * 320 + 77] = 3'b010;
    probe(75, 80, 203, 208, 3'b010);
    wait_done(++exp_done);

    // Inverted column bounds: empty region.
    probe(10, 5, 0, 0, 3'b000);
    wait_done(++exp_done);

    // Bottom-right corner with both bounds past the edge (255 is the largest encodable row).
    fill_rand(3);
    probe(318, 400, 238, 255, int'(fb[76478]));
    wait_done(++exp_done);

    // Origin beyond the screen: empty.
    probe(330, 340, 0, 3, 3'b000);
    wait_done(++exp_done);
    probe(0, 3, 245, 250, 3'b000);
    wait_done(++exp_done);

    // Consumer stalls the response for 5 cycles.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    probe(100, 103, 50, 51, 1);
    for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
    chk("hold_rsp_valid", 32'(rsp_valid), 1);
    h_hit = 32'(rsp_hit);
    h_x   = 32'(rsp_hit_x);
    h_y   = 32'(rsp_hit_y);
    h_cnt = 32'(rsp_count);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid",     32'(rsp_valid), 1);
      chk("hold_hit",       32'(rsp_hit),   h_hit);
      chk("hold_hit_x",     32'(rsp_hit_x), h_x);
      chk("hold_hit_y",     32'(rsp_hit_y), h_y);
      chk("hold_count",     32'(rsp_count), h_cnt);
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("req_ready_after_rsp", 32'(req_ready), 1);
    wait_done(++exp_done);

    // Reset in the 20th scan cycle aborts the probe.
    probe(0, 99, 10, 12, 1);
    k = 0;
    for (int i = 0; i < 100 && k < 20; i++) begin
      @(negedge clk);
      if (rd_en) k++;
    end
    chk("abort_scan_cycles", k, 20);
    rst = 1'b1;
    #1;
    chk("abort_rd_en",     32'(rd_en),     0);
    chk("abort_rd_addr",   32'(rd_addr),   0);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_req_ready", 32'(req_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 0);
    end

    // Normal probe after the abort.
    fill_rand(3);
    probe(5, 12, 3, 5, 2);
    wait_done(++exp_done);

    // Random small regions, including clipped and empty ones.
    for (int t = 0; t < 8; t++) begin
      int x0, y0;
      x0 = $urandom_range(0, 325);
      y0 = $urandom_range(0, 242);
      probe(x0, x0 + $urandom_range(0, 7) - 1, y0, y0 + $urandom_range(0, 4), $urandom_range(0, 3));
      wait_done(++exp_done);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
